// File: rtl/exe2mem_skid_reg_if.sv
// EX->MEM pipeline register bundle: EX-side inputs, MEM-side handshake, flush, forwarding tap.
// The slave modport is the register itself; the master modport is the surrounding pipeline.
interface exe2mem_skid_reg_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              WB_EN_IN;
    logic              MEM_R_EN_IN;
    logic              MEM_W_EN_IN;
    logic [WORD_W-1:0] PCIn;
    logic [WORD_W-1:0] ALUResIn;
    logic [WORD_W-1:0] STValIn;
    logic [ADDR_W-1:0] destIn;
    logic              out_valid;
    logic              out_ready;
    logic              WB_EN;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [WORD_W-1:0] PC;
    logic [WORD_W-1:0] ALURes;
    logic [WORD_W-1:0] STVal;
    logic [ADDR_W-1:0] dest;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_dest;
    logic [WORD_W-1:0] fwd_data;
    logic [1:0]        occupancy;

    modport slave (
        input  flush, in_valid, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
               PCIn, ALUResIn, STValIn, destIn, out_ready,
        output in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN,
               PC, ALURes, STVal, dest, fwd_valid, fwd_dest, fwd_data, occupancy
    );

    modport master (
        output flush, in_valid, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
               PCIn, ALUResIn, STValIn, destIn, out_ready,
        input  in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN,
               PC, ALURes, STVal, dest, fwd_valid, fwd_dest, fwd_data, occupancy
    );
endinterface

// File: rtl/exe2mem_skid_reg.sv
// EX->MEM pipeline register with valid/ready handshake, synchronous flush and forwarding tap.
// Define EXE2MEM_SKID_EN to add a skid entry behind main so in_ready is a pure register output.
module exe2mem_skid_reg #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    exe2mem_skid_reg_if.slave   bus
);
    typedef struct packed {
        logic              wb;
        logic              mr;
        logic              mw;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] alu;
        logic [WORD_W-1:0] st;
        logic [ADDR_W-1:0] dest;
    } ent_t;

    ent_t in_ent;
    ent_t main_q, main_d;
    logic main_vld_q, main_vld_d;
    logic pop, accept;

    assign in_ent = '{wb:   bus.WB_EN_IN,
                      mr:   bus.MEM_R_EN_IN,
                      mw:   bus.MEM_W_EN_IN,
                      pc:   bus.PCIn,
                      alu:  bus.ALUResIn,
                      st:   bus.STValIn,
                      dest: bus.destIn};

    assign pop    = main_vld_q & bus.out_ready;
    assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

`ifdef EXE2MEM_SKID_EN
    ent_t skid_q, skid_d;
    logic skid_vld_q, skid_vld_d;

    assign bus.in_ready  = ~skid_vld_q;
    assign bus.occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

    // Flush only drops valid bits; data registers keep their contents.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (bus.flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (pop) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q || pop) begin
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_ent;
                skid_vld_d = 1'b1;
            end
        end else if (pop) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`else
    assign bus.in_ready  = ~main_vld_q | bus.out_ready;
    assign bus.occupancy = {1'b0, main_vld_q};

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (bus.flush) begin
            main_vld_d = 1'b0;
        end else if (accept) begin
            main_d     = in_ent;
            main_vld_d = 1'b1;
        end else if (pop) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end

    // Control bits are gated so a bubble never writes memory or the register file.
    assign bus.out_valid = main_vld_q;
    assign bus.WB_EN     = main_q.wb & main_vld_q;
    assign bus.MEM_R_EN  = main_q.mr & main_vld_q;
    assign bus.MEM_W_EN  = main_q.mw & main_vld_q;
    assign bus.PC        = main_q.pc;
    assign bus.ALURes    = main_q.alu;
    assign bus.STVal     = main_q.st;
    assign bus.dest      = main_q.dest;

    // Loads have no result yet in this stage, so they are not forwarded.
    assign bus.fwd_valid = bus.WB_EN & ~bus.MEM_R_EN;
    assign bus.fwd_dest  = main_q.dest;
    assign bus.fwd_data  = main_q.alu;
endmodule

// File: tb/tb_exe2mem_skid_reg.sv
// Scoreboard bench for exe2mem_skid_reg: the reference is a FIFO of depth 1 (or 2 with skid).
module tb_exe2mem_skid_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exe2mem_skid_reg_if #(.WORD_W(32), .ADDR_W(5)) bus ();
    exe2mem_skid_reg #(.WORD_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          wb, mr, mw;
        logic [31:0] pc, alu, st;
        logic [4:0]  dest;
    } exp_t;

    exp_t q[$];
    exp_t last_head;
    exp_t e;
    bit   acc_last;
    bit   m_pop, m_acc, v;
    int   checks = 0;
    int   errors = 0;

    function automatic bit model_in_ready();
`ifdef EXE2MEM_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || bus.out_ready;
`endif
    endfunction

    function automatic exp_t cur_in();
        exp_t x;
        x.wb = bus.WB_EN_IN; x.mr = bus.MEM_R_EN_IN; x.mw = bus.MEM_W_EN_IN;
        x.pc = bus.PCIn; x.alu = bus.ALUResIn; x.st = bus.STValIn; x.dest = bus.destIn;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: accepted entries queue up, MEM pops the head, flush empties everything.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            last_head = '{default: 0};
            acc_last  = 1'b0;
        end else begin
            m_pop    = q.size() > 0 && bus.out_ready;
            m_acc    = bus.in_valid && model_in_ready() && !bus.flush;
            acc_last = m_acc;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_acc) q.push_back(cur_in());
                if (q.size() > 0) last_head = q[0];
            end
        end
    end

    // Monitor: compares every presented output against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            v = q.size() > 0;
            e = v ? q[0] : last_head;
            chk("out_valid", 32'(bus.out_valid), 32'(v));
            chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
            chk("in_ready",  32'(bus.in_ready), 32'(model_in_ready()));
            chk("WB_EN",     32'(bus.WB_EN), 32'(v & e.wb));
            chk("MEM_R_EN",  32'(bus.MEM_R_EN), 32'(v & e.mr));
            chk("MEM_W_EN",  32'(bus.MEM_W_EN), 32'(v & e.mw));
            chk("PC",        bus.PC, e.pc);
            chk("ALURes",    bus.ALURes, e.alu);
            chk("STVal",     bus.STVal, e.st);
            chk("dest",      32'(bus.dest), 32'(e.dest));
            chk("fwd_valid", 32'(bus.fwd_valid), 32'(v & e.wb & ~e.mr));
            chk("fwd_dest",  32'(bus.fwd_dest), 32'(e.dest));
            chk("fwd_data",  bus.fwd_data, e.alu);
        end
    end

    task automatic drive(input bit iv, input bit wb, input bit mr, input bit mw,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] d,
                         input bit ordy, input bit fl);
        bus.in_valid = iv; bus.WB_EN_IN = wb; bus.MEM_R_EN_IN = mr; bus.MEM_W_EN_IN = mw;
        bus.PCIn = pc; bus.ALUResIn = alu; bus.STValIn = alu ^ 32'h5A5A_0000; bus.destIn = d;
        bus.out_ready = ordy; bus.flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.WB_EN_IN = 0; bus.MEM_R_EN_IN = 0; bus.MEM_W_EN_IN = 0;
        bus.PCIn = 0; bus.ALUResIn = 0; bus.STValIn = 0; bus.destIn = 0;
        bus.out_ready = 0; bus.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_ALURes", bus.ALURes, 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        rst = 1'b0;

        // Single transfer, then back-to-back streaming.
        drive(1, 1, 0, 0, 32'h10, 32'hA5, 5'd3, 1, 0);
        for (int i = 1; i <= 8; i++) drive(1, 1, 0, i[0], 32'h100 + i, i, 5'(i), 1, 0);
        idle(2);

        // Downstream stall builds up, then drains.
        drive(1, 1, 0, 0, 32'h20, 32'h11, 5'd4, 0, 0);
        drive(1, 1, 0, 0, 32'h24, 32'h22, 5'd5, 0, 0);
        drive(1, 1, 0, 0, 32'h24, 32'h22, 5'd5, 0, 0);
        idle(4);

        // Flush with a full buffer and a same-cycle input that must be dropped.
        drive(1, 1, 0, 1, 32'h30, 32'h44, 5'd6, 0, 0);
        drive(1, 0, 0, 1, 32'h34, 32'h55, 5'd7, 0, 0);
        drive(1, 1, 1, 1, 32'h38, 32'h33, 5'd8, 0, 1);
        idle(3);

        // Load on the tap, then flush together with a pop.
        drive(1, 1, 1, 0, 32'h40, 32'h66, 5'd9, 1, 0);
        drive(1, 1, 0, 0, 32'h44, 32'h77, 5'd10, 1, 1);
        idle(2);

        // Randomized traffic honouring the EX hold rule.
        for (int i = 0; i < 400; i++) begin
            if (!(bus.in_valid && !acc_last && !bus.flush)) begin
                bus.in_valid    = ($urandom_range(9, 0) < 7);
                bus.WB_EN_IN    = 1'($urandom);
                bus.MEM_R_EN_IN = 1'($urandom);
                bus.MEM_W_EN_IN = 1'($urandom);
                bus.PCIn        = $urandom;
                bus.ALUResIn    = $urandom;
                bus.STValIn     = $urandom;
                bus.destIn      = 5'($urandom_range(31, 0));
            end
            bus.out_ready = ($urandom_range(9, 0) < 6);
            bus.flush     = ($urandom_range(19, 0) == 0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while stalled with data held.
        drive(1, 1, 0, 1, 32'hDEAD_0000, 32'hBEEF, 5'd12, 0, 0);
        drive(1, 1, 0, 1, 32'hDEAD_0004, 32'hCAFE, 5'd13, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_occupancy", 32'(bus.occupancy), 0);
        chk("arst_WB_EN", 32'(bus.WB_EN), 0);
        chk("arst_PC", bus.PC, 0);
        chk("arst_ALURes", bus.ALURes, 0);
        chk("arst_STVal", bus.STVal, 0);
        chk("arst_dest", 32'(bus.dest), 0);
        chk("arst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 1, 0, 0, 32'h50, 32'h88, 5'd14, 1, 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
